// File: rtl/ltl_ste_array.sv
// ltl_ste_array: array of state-transition elements (STEs) for streaming pattern matching.
// A symbol is consumed on each clock edge where run=1. Each STE becomes active on the next
// cycle when two conditions hold: it is enabled (by an active predecessor edge or by its start
// mode) and the current symbol hits its match bitmap. When any active STE is marked as a
// report STE, the symbol index and the report vector are pushed into a report FIFO.
//
// Ports
//   clk, reset            : clock; asynchronous active-high reset
//   run, restart, symbols : consume a symbol; synchronous stream restart (config is kept)
//   cfg_we/sel/state/addr/wdata : config writes, accepted only while run=0
//                           sel 0 match[state][addr], 1 edge[addr->state],
//                           2 start mode[state], 3 report[state]
//   active_state, report_vec : registered activation vector, and that vector masked by report bits
//   rpt_valid/ready/vec/cnt  : report FIFO head with a pop handshake
//   rpt_overflow          : sticky flag, set when a report entry was dropped
module ltl_ste_array #(
  parameter int unsigned SYM_WIDTH  = 8,
  parameter int unsigned N_STATES   = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 32,
  localparam int unsigned StW       = $clog2(N_STATES),
  localparam int unsigned AddrW     = (SYM_WIDTH > StW) ? SYM_WIDTH : StW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 restart,
  input  logic [SYM_WIDTH-1:0] symbols,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [StW-1:0]       cfg_state,
  input  logic [AddrW-1:0]     cfg_addr,
  input  logic [1:0]           cfg_wdata,
  output logic [N_STATES-1:0]  active_state,
  output logic [N_STATES-1:0]  report_vec,
  output logic                 rpt_valid,
  input  logic                 rpt_ready,
  output logic [N_STATES-1:0]  rpt_vec,
  output logic [CNT_WIDTH-1:0] rpt_cnt,
  output logic                 rpt_overflow
);

  localparam int unsigned NSym    = 2 ** SYM_WIDTH;
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);

  // Configuration storage
  logic [N_STATES-1:0] match_q [NSym];      // match_q[symbol][state]
  logic [N_STATES-1:0] edge_q  [N_STATES];  // edge_q[src][dst]
  logic [1:0]          mode_q  [N_STATES];
  logic [N_STATES-1:0] rpt_mask_q;

  logic                 cfg_wr, state_ok, src_ok;
  logic [StW-1:0]       src_idx;
  logic [SYM_WIDTH-1:0] sym_idx;

  assign cfg_wr   = cfg_we & ~run;
  assign src_idx  = cfg_addr[StW-1:0];
  assign sym_idx  = cfg_addr[SYM_WIDTH-1:0];
  // Guard against indices past N_STATES when N_STATES is not a power of two.
  assign state_ok = 32'(cfg_state) < N_STATES;
  assign src_ok   = 32'(src_idx) < N_STATES;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NSym; s++) match_q[s] <= '0;
      for (int s = 0; s < N_STATES; s++) begin
        edge_q[s] <= '0;
        mode_q[s] <= 2'b00;
      end
      rpt_mask_q <= '0;
    end else if (cfg_wr && state_ok) begin
      case (cfg_sel)
        2'd0: match_q[sym_idx][cfg_state] <= cfg_wdata[0];
        2'd1: if (src_ok) edge_q[src_idx][cfg_state] <= cfg_wdata[0];
        2'd2: mode_q[cfg_state] <= cfg_wdata;
        default: rpt_mask_q[cfg_state] <= cfg_wdata[0];
      endcase
    end
  end

  // Stream state
  logic [N_STATES-1:0]  active_q, active_d;
  logic                 sod_q, sod_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]        count_q, count_d;

  logic [N_STATES-1:0] enable, next_active, next_rpt;
  logic                step, push_req, push, pop, full;

  always_comb begin
    enable = '0;
    for (int i = 0; i < N_STATES; i++) begin
      for (int j = 0; j < N_STATES; j++) begin
        enable[i] = enable[i] | (active_q[j] & edge_q[j][i]);
      end
      if (mode_q[i] == 2'b01 && sod_q) enable[i] = 1'b1;
      if (mode_q[i] == 2'b10) enable[i] = 1'b1;
    end
  end

  assign next_active = enable & match_q[symbols];
  assign next_rpt    = next_active & rpt_mask_q;
  assign step        = run & ~restart;
  assign push_req    = step & (|next_rpt);
  assign full        = (count_q == FullCnt);
  assign pop         = (count_q != '0) & rpt_ready & ~restart;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push        = push_req & (~full | pop);

  always_comb begin
    active_d = active_q;
    sod_d    = sod_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (restart) begin
      active_d = '0;
      sod_d    = 1'b1;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (run) begin
        active_d = next_active;
        sod_d    = 1'b0;
        cnt_d    = cnt_q + CNT_WIDTH'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
      if (push_req && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= '0;
      sod_q    <= 1'b1;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      active_q <= active_d;
      sod_q    <= sod_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Report FIFO payload; validity lives entirely in the pointers and count, so no reset.
  logic [N_STATES-1:0]  fvec_q [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0] fcnt_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      fvec_q[wr_ptr_q] <= next_rpt;
      fcnt_q[wr_ptr_q] <= cnt_q;
    end
  end

  assign active_state = active_q;
  assign report_vec   = active_q & rpt_mask_q;
  assign rpt_valid    = (count_q != '0);
  // Gate the head so stale payload never shows while the FIFO is empty or in reset.
  assign rpt_vec      = rpt_valid ? fvec_q[rd_ptr_q] : '0;
  assign rpt_cnt      = rpt_valid ? fcnt_q[rd_ptr_q] : '0;
  assign rpt_overflow = ovf_q;

endmodule
